// File: rtl/audio_pkg.sv
// Shared types for the audio record/play path: recorder state encoding and
// the sample/address widths used by the init sequencer, recorder and player.
package audio_pkg;

  localparam int AUD_DATA_W  = 16;
  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LR,
    S_SHIFT,
    S_PAUSE
  } rec_state_t;

endpackage

// File: rtl/aud_sync_edge.sv
// Two-flop synchronizer for an asynchronous codec line, plus a third flop
// so rising and falling edges can be detected in the system clock domain.
module aud_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic sync_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      meta_q    <= i_async;
      sync_q    <= meta_q;
      sync_prev <= sync_q;
    end
  end

  assign o_sync = sync_q;
  assign o_rise = !sync_prev && sync_q;
  assign o_fall = sync_prev && !sync_q;

endmodule

// File: rtl/audio_adc_recorder.sv
// Captures the left I2S channel from the codec ADC and presents each 16-bit
// sample, tagged with its SRAM word address, on a single-entry valid/ready port.
module audio_adc_recorder
  import audio_pkg::*;
#(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = SRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_bclk,
  input  logic              i_aud_adclrck,
  input  logic              i_aud_adcdat,
  output logic [DATA_W-1:0] o_sample,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(DATA_W);

  rec_state_t state;
  rec_state_t next_state;

  logic bclk_rise;
  logic bclk_sync_unused;
  logic bclk_fall_unused;
  logic lrck_sync;
  logic lrck_rise_unused;
  logic lrck_fall_unused;
  logic dat_sync;
  logic dat_rise_unused;
  logic dat_fall_unused;

  logic              lrck_prev;
  logic [DATA_W-2:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] new_word;

  logic left_start;
  logic last_bit;
  logic accept;
  logic full_hit;
  logic start_new;
  logic arm_shift;
  logic do_shift;
  logic sample_done;

  aud_sync_edge u_sync_bclk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_aud_bclk),
    .o_sync  (bclk_sync_unused),
    .o_rise  (bclk_rise),
    .o_fall  (bclk_fall_unused)
  );

  aud_sync_edge u_sync_lrck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_aud_adclrck),
    .o_sync  (lrck_sync),
    .o_rise  (lrck_rise_unused),
    .o_fall  (lrck_fall_unused)
  );

  aud_sync_edge u_sync_dat (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_aud_adcdat),
    .o_sync  (dat_sync),
    .o_rise  (dat_rise_unused),
    .o_fall  (dat_fall_unused)
  );

  // Left frame begins on the BCLK rise that first sees LRCK low; that edge is the I2S delay bit.
  assign left_start = bclk_rise && lrck_prev && !lrck_sync;
  assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
  assign accept     = o_valid && i_ready;
  assign full_hit   = accept && (o_addr == MAX_ADDR);
  assign new_word   = {shift_reg, dat_sync};
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (i_start) next_state = S_WAIT_LR;
      end
      S_WAIT_LR: begin
        if (i_stop)          next_state = S_IDLE;
        else if (i_pause)    next_state = S_PAUSE;
        else if (left_start) next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_stop)                     next_state = S_IDLE;
        else if (i_pause)               next_state = S_PAUSE;
        else if (bclk_rise && last_bit) next_state = S_WAIT_LR;
      end
      S_PAUSE: begin
        if (i_stop)       next_state = S_IDLE;
        else if (i_start) next_state = S_WAIT_LR;
      end
      default: next_state = S_IDLE;
    endcase
    // Accepting the last writable word ends the recording regardless of controls.
    if (full_hit) next_state = S_IDLE;
  end

  always_comb begin
    start_new   = 1'b0;
    arm_shift   = 1'b0;
    do_shift    = 1'b0;
    sample_done = 1'b0;
    unique case (state)
      S_IDLE:    start_new = i_start && !full_hit;
      S_WAIT_LR: arm_shift = left_start && !i_stop && !i_pause;
      S_SHIFT: begin
        do_shift    = bclk_rise && !i_stop && !i_pause;
        sample_done = do_shift && last_bit && !full_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrck_prev <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (bclk_rise) lrck_prev <= lrck_sync;
      if (arm_shift) begin
        bit_cnt <= '0;
      end else if (do_shift) begin
        shift_reg <= new_word[DATA_W-2:0];
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Single holding register: a completed sample is kept only if the slot is free
  // or is being emptied this same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sample  <= '0;
      o_addr    <= '0;
      o_valid   <= 1'b0;
      o_len     <= '0;
      o_full    <= 1'b0;
      o_overrun <= 1'b0;
      wr_addr   <= '0;
    end else begin
      if (sample_done && (!o_valid || i_ready)) begin
        o_sample <= new_word;
        o_addr   <= accept ? (wr_addr + 1'b1) : wr_addr;
        o_valid  <= 1'b1;
      end else begin
        if (sample_done) o_overrun <= 1'b1;
        if (accept)      o_valid   <= 1'b0;
      end

      if (start_new) begin
        wr_addr   <= '0;
        o_len     <= '0;
        o_full    <= 1'b0;
        o_overrun <= 1'b0;
      end else if (accept) begin
        if (!full_hit)    wr_addr <= wr_addr + 1'b1;
        if (o_len != '1)  o_len   <= o_len + 1'b1;
        if (full_hit)     o_full  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_recorder.sv
// Directed bench for audio_adc_recorder: an I2S codec model drives free-running
// frames while one linear sequence records, pauses, stops and resets the block.
module tb_audio_adc_recorder;

  localparam int CLK_HALF    = 10;
  localparam int BCLK_HALF   = 325;
  localparam int BCLK_PERIOD = 2 * BCLK_HALF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_lrck = 1'b1;
  logic        aud_dat = 1'b0;
  logic        i_ready = 1'b1;
  logic [15:0] o_sample;
  logic [19:0] o_addr;
  logic        o_valid;
  logic [19:0] o_len;
  logic        o_busy;
  logic        o_full;
  logic        o_overrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] left_word = 16'h0000;
  logic [35:0] acc_q[$];
  event        left_start;
  event        right_start;

  audio_adc_recorder #(
    .DATA_W   (16),
    .ADDR_W   (20),
    .MAX_ADDR (20'd3)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_stop        (i_stop),
    .i_aud_bclk    (aud_bclk),
    .i_aud_adclrck (aud_lrck),
    .i_aud_adcdat  (aud_dat),
    .o_sample      (o_sample),
    .o_addr        (o_addr),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_len         (o_len),
    .o_busy        (o_busy),
    .o_full        (o_full),
    .o_overrun     (o_overrun)
  );

  always #CLK_HALF i_clk = ~i_clk;

  // Codec changes LRCK/data on BCLK fall; MSB goes out one BCLK after the LRCK edge.
  task automatic driveHalf(input logic lr, input logic [15:0] word);
    for (int k = 0; k < 32; k++) begin
      aud_bclk = 1'b0;
      if (k == 0) aud_lrck = lr;
      aud_dat = (k >= 1 && k <= 16) ? word[16-k] : 1'b0;
      #BCLK_HALF;
      aud_bclk = 1'b1;
      #BCLK_HALF;
    end
  endtask

  initial begin
    logic [15:0] cur_left;
    forever begin
      cur_left = left_word;
      ->left_start;
      driveHalf(1'b0, cur_left);
      ->right_start;
      driveHalf(1'b1, 16'hFFFF);
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) acc_q.push_back({o_addr, o_sample});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAccepted(input string tag, input int idx, input logic [15:0] exp_sample,
                               input logic [19:0] exp_addr);
    logic [35:0] e;
    e = (idx < acc_q.size()) ? acc_q[idx] : {36{1'b1}};
    checkOutput({tag, " sample"}, {16'h0, e[15:0]}, {16'h0, exp_sample});
    checkOutput({tag, " addr"}, {12'h0, e[35:16]}, {12'h0, exp_addr});
  endtask

  task automatic applyStimulus(input logic start, input logic pause, input logic stop);
    @(posedge i_clk);
    #1;
    i_start = start;
    i_pause = pause;
    i_stop  = stop;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic setReady(input logic rdy);
    @(posedge i_clk);
    #1;
    i_ready = rdy;
  endtask

  initial begin
    $display("[TB] reset");
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rst valid", 32'(o_valid), 32'd0);
    checkOutput("rst busy", 32'(o_busy), 32'd0);
    checkOutput("rst len", 32'(o_len), 32'd0);
    checkOutput("rst sample", 32'(o_sample), 32'd0);
    checkOutput("rst full", 32'(o_full), 32'd0);

    $display("[TB] test 1: two left frames, right channel ignored");
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    left_word = 16'h8001;
    @(left_start);
    left_word = 16'h7FFE;
    @(left_start);
    left_word = 16'h1111;
    @(left_start);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge i_clk);
    checkOutput("t1 count", 32'(acc_q.size()), 32'd2);
    checkAccepted("t1 first", 0, 16'h8001, 20'd0);
    checkAccepted("t1 second", 1, 16'h7FFE, 20'd1);
    checkOutput("t1 len", 32'(o_len), 32'd2);
    checkOutput("t1 busy", 32'(o_busy), 32'd0);

    $display("[TB] test 2: backpressure and overrun");
    acc_q.delete();
    setReady(1'b0);
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    left_word = 16'hA5C3;
    @(left_start);
    left_word = 16'h3C5A;
    @(right_start);
    @(negedge i_clk);
    checkOutput("t2 valid1", 32'(o_valid), 32'd1);
    checkOutput("t2 sample1", 32'(o_sample), 32'hA5C3);
    checkOutput("t2 addr1", 32'(o_addr), 32'd0);
    checkOutput("t2 ovr1", 32'(o_overrun), 32'd0);
    @(right_start);
    @(negedge i_clk);
    checkOutput("t2 held sample", 32'(o_sample), 32'hA5C3);
    checkOutput("t2 held valid", 32'(o_valid), 32'd1);
    checkOutput("t2 overrun", 32'(o_overrun), 32'd1);
    left_word = 16'h0F0F;
    setReady(1'b1);
    repeat (3) @(negedge i_clk);
    checkOutput("t2 drained", 32'(o_valid), 32'd0);
    checkOutput("t2 count", 32'(acc_q.size()), 32'd1);
    checkAccepted("t2 first", 0, 16'hA5C3, 20'd0);
    @(left_start);
    @(right_start);
    @(negedge i_clk);
    checkAccepted("t2 next", 1, 16'h0F0F, 20'd1);
    checkOutput("t2 ovr sticky", 32'(o_overrun), 32'd1);
    @(left_start);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] test 3: pause mid-sample and resume");
    acc_q.delete();
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    left_word = 16'h1357;
    @(left_start);
    left_word = 16'hDEAD;
    @(left_start);
    left_word = 16'hBEEF;
    #(8 * BCLK_PERIOD);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("t3 paused busy", 32'(o_busy), 32'd1);
    repeat (3) @(left_start);
    left_word = 16'h2468;
    @(right_start);
    @(negedge i_clk);
    checkOutput("t3 paused count", 32'(acc_q.size()), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(left_start);
    left_word = 16'h5555;
    @(right_start);
    @(negedge i_clk);
    checkOutput("t3 count", 32'(acc_q.size()), 32'd2);
    checkAccepted("t3 first", 0, 16'h1357, 20'd0);
    checkAccepted("t3 resumed", 1, 16'h2468, 20'd1);
    checkOutput("t3 len", 32'(o_len), 32'd2);
    @(left_start);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] test 4: recording fills up to MAX_ADDR");
    acc_q.delete();
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      left_word = 16'h0101 * 16'(i);
      @(left_start);
    end
    @(right_start);
    @(negedge i_clk);
    checkOutput("t4 count", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkAccepted("t4 entry", i, 16'h0101 * 16'(i + 1), 20'(i));
    end
    checkOutput("t4 full", 32'(o_full), 32'd1);
    checkOutput("t4 busy", 32'(o_busy), 32'd0);
    checkOutput("t4 len", 32'(o_len), 32'd4);
    checkOutput("t4 valid", 32'(o_valid), 32'd0);

    $display("[TB] test 5: stop with a pending sample");
    acc_q.delete();
    setReady(1'b0);
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    checkOutput("t5 full cleared", 32'(o_full), 32'd0);
    checkOutput("t5 len cleared", 32'(o_len), 32'd0);
    checkOutput("t5 busy", 32'(o_busy), 32'd1);
    left_word = 16'hC0DE;
    @(left_start);
    left_word = 16'h0000;
    @(right_start);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (50) @(negedge i_clk);
    checkOutput("t5 idle", 32'(o_busy), 32'd0);
    checkOutput("t5 held valid", 32'(o_valid), 32'd1);
    checkOutput("t5 held sample", 32'(o_sample), 32'hC0DE);
    setReady(1'b1);
    repeat (3) @(negedge i_clk);
    checkOutput("t5 drained", 32'(o_valid), 32'd0);
    checkAccepted("t5 entry", 0, 16'hC0DE, 20'd0);
    checkOutput("t5 len", 32'(o_len), 32'd1);

    $display("[TB] test 6: reset mid-shift");
    acc_q.delete();
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    left_word = 16'hFACE;
    @(left_start);
    left_word = 16'h1234;
    @(left_start);
    @(negedge i_clk);
    checkOutput("t6 len before", 32'(o_len), 32'd1);
    #(8 * BCLK_PERIOD);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("t6 sample", 32'(o_sample), 32'd0);
    checkOutput("t6 addr", 32'(o_addr), 32'd0);
    checkOutput("t6 valid", 32'(o_valid), 32'd0);
    checkOutput("t6 len", 32'(o_len), 32'd0);
    checkOutput("t6 busy", 32'(o_busy), 32'd0);
    checkOutput("t6 full", 32'(o_full), 32'd0);
    checkOutput("t6 overrun", 32'(o_overrun), 32'd0);
    acc_q.delete();
    left_word = 16'h5A5A;
    @(right_start);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(left_start);
    @(right_start);
    @(negedge i_clk);
    checkOutput("t6 count", 32'(acc_q.size()), 32'd1);
    checkAccepted("t6 restart", 0, 16'h5A5A, 20'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
